// File: rtl/serial_adder.sv
// =============================================================================
// Module     : serial_adder
// Description: Bit-serial WIDTH-bit adder (one full-adder cell, one carry flop)
//              with start/busy/done handshake, carry-out and signed overflow.
//              Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
// Revision   : 1.0 - initial release
// =============================================================================
`default_nettype none

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [0:0]         c_IDLE  = 1'b0;
    localparam logic [0:0]         c_RUN   = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-2:0]   r_ss;
    logic               r_c;

    logic [WIDTH-1:0]   w_b_ld;
    logic               w_c_ld;
    logic               w_s;
    logic               w_c_nxt;
    logic               w_accept;
    logic               w_last;

`ifdef SERIAL_ADDER_SUB_EN
    // a - b - cin == a + ~b + ~cin
    assign w_b_ld = sub ? ~b : b;
    assign w_c_ld = cin ^ sub;
`else
    assign w_b_ld = b;
    assign w_c_ld = cin;
`endif

    assign w_s      = r_sa[0] ^ r_sb[0] ^ r_c;
    assign w_c_nxt  = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_c) | (r_sb[0] & r_c);
    assign w_accept = (r_state == c_IDLE) && start;
    assign w_last   = (r_state == c_RUN) && (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (start)             w_state_nxt = c_RUN;
            c_RUN:   if (r_cnt == c_LAST)   w_state_nxt = c_IDLE;
            default:                        w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == c_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_sa  <= '0;
            r_sb  <= '0;
            r_ss  <= '0;
            r_c   <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= w_last;
            if (w_accept) begin
                r_sa  <= a;
                r_sb  <= w_b_ld;
                r_c   <= w_c_ld;
                r_cnt <= '0;
            end else if (r_state == c_RUN) begin
                r_sa  <= r_sa >> 1;
                r_sb  <= r_sb >> 1;
                r_c   <= w_c_nxt;
                r_ss  <= (r_ss >> 1) | ((WIDTH-1)'(w_s) << (WIDTH - 2));
                r_cnt <= r_cnt + c_CNT_W'(1);
                // On the MSB step r_c is the carry into the MSB
                if (w_last) begin
                    sum  <= {w_s, r_ss};
                    cout <= w_c_nxt;
                    ovf  <= r_c ^ w_c_nxt;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed table, corner
// sequences and randomized operations against an arithmetic reference model.
`default_nettype none

module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks;
    int failures;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] esum;
        logic         ecout;
        logic         eovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mci,
                         input logic msub, output logic [W-1:0] es, output logic ec,
                         output logic eo);
        int ur;
        int sr;
        int sa;
        int sb;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (!msub) begin
            ur = int'(ma) + int'(mb) + int'(mci);
            sr = sa + sb + int'(mci);
            ec = (ur > 255);
        end else begin
            ur = int'(ma) - int'(mb) - int'(mci);
            sr = sa - sb - int'(mci);
            ec = (ur >= 0);
        end
        es = ur[W-1:0];
        eo = (sr > 127) || (sr < -128);
    endtask

    // Drive operands with start high and let the next edge accept them
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ici,
                         input logic isub);
        a     = ia;
        b     = ib;
        cin   = ici;
        sub   = isub;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        cin   = 1'b0;
    endtask

    // Follow edges 1..W after acceptance, checking busy/done timing
    task automatic wait_done(input string name);
        for (int k = 1; k <= W; k++) begin
            @(posedge clk);
            #1;
            if (k < W) begin
                if (busy !== 1'b1 || done !== 1'b0) begin
                    check({name, " busy/done mid-op"}, {busy, done}, 2'b10);
                end
            end else begin
                check({name, " done/busy at edge W"}, {done, busy}, 2'b10);
            end
        end
    endtask

    task automatic check_result(input string name, input logic [W-1:0] es, input logic ec,
                                input logic eo);
        check({name, " sum"},  sum,  es);
        check({name, " cout"}, cout, ec);
        check({name, " ovf"},  ovf,  eo);
    endtask

    vec_t         vecs[5];
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        sub      = 1'b0;

        vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset sum",  sum,  '0);
        check("reset cout", cout, 1'b0);
        check("reset ovf",  ovf,  1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
            wait_done($sformatf("vec%0d", i));
            check_result($sformatf("vec%0d", i), vecs[i].esum, vecs[i].ecout, vecs[i].eovf);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d done width", i), done, 1'b0);
        end

        // start re-pulsed mid-operation is ignored
        issue(8'h35, 8'h4A, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        a     = 8'h01;
        b     = 8'h01;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 4; k <= W; k++) begin
            @(posedge clk);
            #1;
        end
        check("ignore done", done, 1'b1);
        check_result("ignore", 8'h7F, 1'b0, 1'b0);

        // back-to-back: start during the done cycle
        issue(8'h7F, 8'h01, 1'b0, 1'b0);
        check("b2b held sum", sum, 8'h7F);
        check("b2b busy", busy, 1'b1);
        wait_done("b2b");
        check_result("b2b", 8'h80, 1'b0, 1'b1);
        @(posedge clk);
        #1;

        // asynchronous reset mid-operation
        issue(8'h12, 8'h34, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst busy", busy, 1'b0);
        check("midrst done", done, 1'b0);
        check("midrst sum",  sum,  '0);
        check("midrst cout", cout, 1'b0);
        check("midrst ovf",  ovf,  1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 12; k++) begin
                @(posedge clk);
                #1;
                if (done === 1'b1) seen++;
            end
            check("midrst no done", seen, 0);
        end
        issue(8'h35, 8'h4A, 1'b0, 1'b0);
        wait_done("postrst");
        check_result("postrst", 8'h7F, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        issue(8'h10, 8'h01, 1'b0, 1'b1);
        wait_done("sub1");
        check("sub1 sum", sum, 8'h0F);
        check("sub1 cout", cout, 1'b1);
        issue(8'h00, 8'h01, 1'b0, 1'b1);
        wait_done("sub2");
        check("sub2 sum", sum, 8'hFF);
        check("sub2 cout", cout, 1'b0);
        issue(8'h80, 8'h01, 1'b0, 1'b1);
        wait_done("sub3");
        check("sub3 sum", sum, 8'h7F);
        check("sub3 ovf", ovf, 1'b1);
`endif

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            model(ra, rb, rc, rs, es, ec, eo);
            issue(ra, rb, rc, rs);
            wait_done($sformatf("rand%0d", i));
            check_result($sformatf("rand%0d", i), es, ec, eo);
            if (($urandom % 2) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
